mem_readback_streamer: RTL

- Reader-side companion to the team's inferred block-RAM `memory` module. Drives that RAM's read port to sweep a contiguous address range.
- Absorbs the RAM's 1-cycle registered read latency.
- Streams each word out over a valid/ready interface with backpressure, and accumulates an XOR checksum.
- Used to read back and verify RAM contents after bitstream-driven reinitialisation.

---
 rtl/mem_readback_streamer.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/mem_readback_streamer.sv
// Sweeps a contiguous address range of an attached 1-cycle-latency block RAM and
// streams each word out over valid/ready, keeping a running XOR checksum.
module mem_readback_streamer #(
  parameter int WID_MEM    = 36,
  parameter int DEPTH_MEM  = 512,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [31:0]        base_addr,
  input  logic [31:0]        word_count,
  output logic [31:0]        raddr,
  input  logic [WID_MEM-1:0] mem_dout,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [WID_MEM-1:0] m_data,
  output logic               m_last,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [WID_MEM-1:0] checksum
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [31:0]        count_q;
  logic [31:0]        issued_q;
  logic               err_q;
  // Two-stage in-flight tracker: stage 1 = address on raddr, stage 2 = data on mem_dout.
  logic               pend1_q, pend1_last_q;
  logic               pend2_q, pend2_last_q;

  logic [WID_MEM-1:0] fifo_data [FIFO_DEPTH];
  logic               fifo_last [FIFO_DEPTH];
  logic [PW-1:0]      wr_ptr, rd_ptr;
  logic [CW-1:0]      fifo_cnt;

  logic               accept, zero_start, bad_start;
  logic               issue, issue_last, room;
  logic               push, pop;
  logic [31:0]        next_addr, reserved;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Reads in flight count against FIFO space so a returning word always has a slot.
  always_comb begin
    reserved  = 32'(fifo_cnt) + 32'(pend1_q) + 32'(pend2_q);
    room      = (reserved < 32'(FIFO_DEPTH));
    next_addr = (raddr == 32'(DEPTH_MEM - 1)) ? 32'd0 : raddr + 32'd1;
    push      = pend2_q;
    m_valid   = (fifo_cnt != '0);
    m_data    = m_valid ? fifo_data[rd_ptr] : '0;
    m_last    = m_valid & fifo_last[rd_ptr];
    pop       = m_valid & m_ready;
    busy      = (state_q == RUN) || (state_q == DRAIN);
    done      = (state_q == DONE);
    err       = done & err_q;
  end

  // NOTE: every signal driven here gets a default first, so no path infers a latch.
  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    zero_start = 1'b0;
    bad_start  = 1'b0;
    issue      = 1'b0;
    issue_last = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (base_addr >= 32'(DEPTH_MEM)) begin
            bad_start = 1'b1;
            state_d   = DONE;
          end else if (word_count == 32'd0) begin
            zero_start = 1'b1;
            state_d    = DONE;
          end else begin
            accept     = 1'b1;
            issue      = 1'b1;
            issue_last = (word_count == 32'd1);
            state_d    = RUN;
          end
        end
      end
      RUN: begin
        if (issued_q == count_q) begin
          state_d = DRAIN;
        end else if (room) begin
          issue      = 1'b1;
          issue_last = (issued_q + 32'd1 == count_q);
        end
      end
      DRAIN: begin
        if (pop && m_last) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      raddr        <= '0;
      count_q      <= '0;
      issued_q     <= '0;
      err_q        <= 1'b0;
      pend1_q      <= 1'b0;
      pend1_last_q <= 1'b0;
      pend2_q      <= 1'b0;
      pend2_last_q <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_cnt     <= '0;
      checksum     <= '0;
    end else begin
      if (accept) begin
        raddr    <= base_addr;
        count_q  <= word_count;
        issued_q <= 32'd1;
      end else if (issue) begin
        raddr    <= next_addr;
        issued_q <= issued_q + 32'd1;
      end

      if (accept || zero_start || bad_start) err_q <= bad_start;

      pend1_q      <= issue;
      pend1_last_q <= issue_last;
      pend2_q      <= pend1_q;
      pend2_last_q <= pend1_last_q;

      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      unique case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase

      if (accept || zero_start) checksum <= '0;
      else if (pop)             checksum <= checksum ^ m_data;
    end
  end

  // NOTE: FIFO storage is deliberately not reset; occupancy gates every read of it.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= mem_dout;
      fifo_last[wr_ptr] <= pend2_last_q;
    end
  end

endmodule
